// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of vga_timing_gen: coordinate request / pixel return towards
// the image source, plus the registered RGB, sync and data-enable towards the DAC.
`timescale 1ns/1ps

interface vga_timing_gen_if;
  logic [10:0] vga_xpos;
  logic [10:0] vga_ypos;
  logic [23:0] vga_data;
  logic [23:0] vga_rgb;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic        vga_frame;

  // Timing generator side: issues coordinates, consumes pixels, drives the DAC.
  modport master (
    output vga_xpos, vga_ypos, vga_rgb, vga_hs, vga_vs, vga_de, vga_frame,
    input  vga_data
  );

  // Pixel source / display side.
  modport slave (
    input  vga_xpos, vga_ypos, vga_rgb, vga_hs, vga_vs, vga_de, vga_frame,
    output vga_data
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator with a latency-matched sync/DE pipeline.
// Optional feature macro: VGA_BORDER_EN (forces a white ring around the active area).
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_DISP   = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_DISP   = 480,
  parameter int V_FRONT  = 10,
  parameter int DATA_LAT = 1
) (
  input  logic             clk_25m,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_END = 11'(H_SYNC);
  localparam logic [10:0] VS_END = 11'(V_SYNC);
  localparam logic [10:0] HA_C   = 11'(HA);
  localparam logic [10:0] HE_C   = 11'(HA + H_DISP);
  localparam logic [10:0] VA_C   = 11'(VA);
  localparam logic [10:0] VE_C   = 11'(VA + V_DISP);
`ifdef VGA_BORDER_EN
  localparam logic [10:0] HR_C   = 11'(HA + H_DISP - 1);
  localparam logic [10:0] VR_C   = 11'(VA + V_DISP - 1);
`endif

  generate
    if (DATA_LAT < 0 || DATA_LAT > 4) begin : g_lat_chk
      $error("vga_timing_gen: DATA_LAT must be within 0..4");
    end
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_cnt_chk
      $error("vga_timing_gen: line/frame totals exceed the 11-bit counters");
    end
  endgenerate

  // Per-pixel qualifiers travelling alongside the pixel source latency.
  typedef struct packed {
`ifdef VGA_BORDER_EN
    logic bd;
`endif
    logic hs;
    logic vs;
    logic de;
    logic fr;
  } flags_t;

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic [10:0] xpos_q, xpos_d;
  logic [10:0] ypos_q, ypos_d;
  logic        h_act, v_act;
  flags_t      raw;
  flags_t      pipe_q [DATA_LAT+1];
  flags_t      tail;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, vs_q, de_q, fr_q;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    hcnt_d = hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops sample together.
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Raw region decode and coordinate request
  // ---------------------------------------------------------------------------
  always_comb begin
    h_act  = (hcnt_q >= HA_C) && (hcnt_q < HE_C);
    v_act  = (vcnt_q >= VA_C) && (vcnt_q < VE_C);
    raw    = '0;
    raw.hs = (hcnt_q < HS_END);
    raw.vs = (vcnt_q < VS_END);
    raw.de = h_act && v_act;
    raw.fr = raw.de && (hcnt_q == HA_C) && (vcnt_q == VA_C);
`ifdef VGA_BORDER_EN
    raw.bd = raw.de && ((hcnt_q == HA_C) || (hcnt_q == HR_C) ||
                        (vcnt_q == VA_C) || (vcnt_q == VR_C));
`endif
  end

  always_comb begin
    xpos_d = '0;
    ypos_d = '0;
    if (raw.de) begin
      xpos_d = hcnt_q - HA_C;
      ypos_d = vcnt_q - VA_C;
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      xpos_q <= '0;
      ypos_q <= '0;
    end else begin
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Qualifier delay line: one stage for the coordinate register, DATA_LAT for
  // the source, so the tail lines up with the vga_data being sampled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25m or negedge rst_n) begin
    // NOTE: this small array is reset on purpose; stale flags must never reach the pins after reset.
    if (!rst_n) begin
      for (int i = 0; i <= DATA_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= raw;
      for (int i = 1; i <= DATA_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = pipe_q[DATA_LAT];

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_comb begin
    rgb_d = '0;
    if (tail.de) begin
`ifdef VGA_BORDER_EN
      rgb_d = tail.bd ? 24'hFF_FFFF : vga.vga_data;
`else
      rgb_d = vga.vga_data;
`endif
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      fr_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= ~tail.hs;
      vs_q  <= ~tail.vs;
      de_q  <= tail.de;
      fr_q  <= tail.fr;
    end
  end

  assign vga.vga_xpos  = xpos_q;
  assign vga.vga_ypos  = ypos_q;
  assign vga.vga_rgb   = rgb_q;
  assign vga.vga_hs    = hs_q;
  assign vga.vga_vs    = vs_q;
  assign vga.vga_de    = de_q;
  assign vga.vga_frame = fr_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized self-checking bench for vga_timing_gen: three reduced rasters
// (DATA_LAT 0/1/3) plus the full 640x480 raster, all checked against an arithmetic model.
`timescale 1ns/1ps

module tb_vga_timing_gen;

  localparam int NI = 4;
  localparam int P_HS  [NI] = '{4, 4, 4, 96};
  localparam int P_HB  [NI] = '{3, 3, 3, 48};
  localparam int P_HD  [NI] = '{10, 10, 10, 640};
  localparam int P_HF  [NI] = '{2, 2, 2, 16};
  localparam int P_VS  [NI] = '{2, 2, 2, 2};
  localparam int P_VB  [NI] = '{2, 2, 2, 33};
  localparam int P_VD  [NI] = '{6, 6, 6, 480};
  localparam int P_VF  [NI] = '{1, 1, 1, 10};
  localparam int P_LAT [NI] = '{0, 1, 3, 1};

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fr;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  obs_t        obs    [NI];
  logic [23:0] data_r [NI];
  logic [23:0] hist   [NI][4];
  logic [7:0]  salt   [NI];

  int n_cmp = 0;
  int n_bad = 0;
  int k     = 0;   // rising edges since reset release; 0 while in reset
  int mode  = 0;   // source behaviour: 0 pattern, 1 constant white, 2 constant black
  int cur_i = 0;

  int last_hf [NI], hs_low [NI], vs_low [NI], de_cnt [NI], white_cnt [NI], last_fr [NI];
  bit p_hs [NI], p_vs [NI], hf_seen [NI], hl_seen [NI], vl_seen [NI], fr_seen [NI], first_done [NI];

  always #20 clk = ~clk;

  vga_timing_gen_if vif0 ();
  vga_timing_gen_if vif1 ();
  vga_timing_gen_if vif2 ();
  vga_timing_gen_if vif3 ();

  vga_timing_gen #(.H_SYNC(4), .H_BACK(3), .H_DISP(10), .H_FRONT(2),
                   .V_SYNC(2), .V_BACK(2), .V_DISP(6), .V_FRONT(1), .DATA_LAT(0))
    u_lat0 (.clk_25m(clk), .rst_n(rst_n), .vga(vif0));
  vga_timing_gen #(.H_SYNC(4), .H_BACK(3), .H_DISP(10), .H_FRONT(2),
                   .V_SYNC(2), .V_BACK(2), .V_DISP(6), .V_FRONT(1), .DATA_LAT(1))
    u_lat1 (.clk_25m(clk), .rst_n(rst_n), .vga(vif1));
  vga_timing_gen #(.H_SYNC(4), .H_BACK(3), .H_DISP(10), .H_FRONT(2),
                   .V_SYNC(2), .V_BACK(2), .V_DISP(6), .V_FRONT(1), .DATA_LAT(3))
    u_lat3 (.clk_25m(clk), .rst_n(rst_n), .vga(vif2));
  vga_timing_gen #(.DATA_LAT(1))
    u_full (.clk_25m(clk), .rst_n(rst_n), .vga(vif3));

  assign obs[0] = {vif0.vga_xpos, vif0.vga_ypos, vif0.vga_rgb, vif0.vga_hs, vif0.vga_vs, vif0.vga_de, vif0.vga_frame};
  assign obs[1] = {vif1.vga_xpos, vif1.vga_ypos, vif1.vga_rgb, vif1.vga_hs, vif1.vga_vs, vif1.vga_de, vif1.vga_frame};
  assign obs[2] = {vif2.vga_xpos, vif2.vga_ypos, vif2.vga_rgb, vif2.vga_hs, vif2.vga_vs, vif2.vga_de, vif2.vga_frame};
  assign obs[3] = {vif3.vga_xpos, vif3.vga_ypos, vif3.vga_rgb, vif3.vga_hs, vif3.vga_vs, vif3.vga_de, vif3.vga_frame};

  assign vif0.vga_data = data_r[0];
  assign vif1.vga_data = data_r[1];
  assign vif2.vga_data = data_r[2];
  assign vif3.vga_data = data_r[3];

  function automatic int ht(int i); return P_HS[i] + P_HB[i] + P_HD[i] + P_HF[i]; endfunction
  function automatic int vt(int i); return P_VS[i] + P_VB[i] + P_VD[i] + P_VF[i]; endfunction
  function automatic int ha(int i); return P_HS[i] + P_HB[i]; endfunction
  function automatic int va(int i); return P_VS[i] + P_VB[i]; endfunction

  function automatic bit visible(int i, int h, int v);
    return (h >= ha(i)) && (h < ha(i) + P_HD[i]) && (v >= va(i)) && (v < va(i) + P_VD[i]);
  endfunction

  // What the downstream pixel source returns for a requested coordinate.
  function automatic logic [23:0] src_val(int i, logic [10:0] xv, logic [10:0] yv, int md);
    case (md)
      0:       return {xv[7:0], yv[7:0], salt[i]};
      1:       return 24'hFF_FFFF;
      default: return 24'h00_0000;
    endcase
  endfunction

  function automatic int ring_expected(int i);
`ifdef VGA_BORDER_EN
    return 2 * P_HD[i] + 2 * P_VD[i] - 4;
`else
    return 0;
`endif
  endfunction

  // Expected pins after rising edge kk, from raster position arithmetic alone.
  function automatic obs_t model(int i, int kk, int md);
    obs_t e;
    int   c, h, v;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (kk >= 1) begin
      c = kk - 1;
      h = c % ht(i);
      v = (c / ht(i)) % vt(i);
      if (visible(i, h, v)) begin
        e.x = 11'(h - ha(i));
        e.y = 11'(v - va(i));
      end
    end
    c = kk - 2 - P_LAT[i];
    if (kk >= 1 && c >= 0) begin
      h    = c % ht(i);
      v    = (c / ht(i)) % vt(i);
      e.hs = !(h < P_HS[i]);
      e.vs = !(v < P_VS[i]);
      if (visible(i, h, v)) begin
        e.de  = 1'b1;
        e.fr  = (h == ha(i)) && (v == va(i));
        e.rgb = src_val(i, 11'(h - ha(i)), 11'(v - va(i)), md);
`ifdef VGA_BORDER_EN
        if (h == ha(i) || h == ha(i) + P_HD[i] - 1 || v == va(i) || v == va(i) + P_VD[i] - 1)
          e.rgb = 24'hFF_FFFF;
`endif
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d k=%0d: got %0h expected %0h", tag, cur_i, k, got, exp);
    end
  endtask

  task automatic compare_inst(input int i);
    obs_t e;
    int   c;
    cur_i = i;
    e = model(i, k, mode);
    check("xpos",  32'(obs[i].x),   32'(e.x));
    check("ypos",  32'(obs[i].y),   32'(e.y));
    check("rgb",   32'(obs[i].rgb), 32'(e.rgb));
    check("hs",    32'(obs[i].hs),  32'(e.hs));
    check("vs",    32'(obs[i].vs),  32'(e.vs));
    check("de",    32'(obs[i].de),  32'(e.de));
    check("frame", 32'(obs[i].fr),  32'(e.fr));
    c = k - 2 - P_LAT[i];
    if (i == 3 && mode == 0 && k >= 1 && c == va(i) * ht(i) + ha(i) + 2)
      check("pix_2_0", 32'(obs[i].rgb), 32'h0002_005A);
  endtask

  task automatic measure(input int i);
    obs_t o;
    bit   hs_fall, hs_rise, vs_fall, vs_rise;
    cur_i   = i;
    o       = obs[i];
    hs_fall = p_hs[i] && !o.hs;
    hs_rise = !p_hs[i] && o.hs;
    vs_fall = p_vs[i] && !o.vs;
    vs_rise = !p_vs[i] && o.vs;
    if (hs_fall) begin
      if (hf_seen[i]) check("hs_period", k - last_hf[i], ht(i));
      hf_seen[i] = 1'b1;
      last_hf[i] = k;
      hl_seen[i] = 1'b1;
      hs_low[i]  = 0;
    end
    if (!o.hs) hs_low[i]++;
    if (hs_rise && hl_seen[i]) check("hs_low", hs_low[i], P_HS[i]);
    if (vs_fall) begin
      check("vs_on_hs_fall", 32'(hs_fall), 1);
      vl_seen[i] = 1'b1;
      vs_low[i]  = 0;
    end
    if (!o.vs) vs_low[i]++;
    if (vs_rise && vl_seen[i]) check("vs_low", vs_low[i], P_VS[i] * ht(i));
    if (o.fr) begin
      if (!first_done[i]) begin
        check("first_frame_lat", k, va(i) * ht(i) + ha(i) + P_LAT[i] + 2);
        first_done[i] = 1'b1;
      end
      if (fr_seen[i]) begin
        check("frame_period", k - last_fr[i], ht(i) * vt(i));
        check("de_per_frame", de_cnt[i], P_HD[i] * P_VD[i]);
        if (mode == 2) check("ring_white", white_cnt[i], ring_expected(i));
      end
      fr_seen[i]   = 1'b1;
      last_fr[i]   = k;
      de_cnt[i]    = 0;
      white_cnt[i] = 0;
    end
    if (o.de) de_cnt[i]++;
    if (o.de && o.rgb == 24'hFF_FFFF) white_cnt[i]++;
    p_hs[i] = o.hs;
    p_vs[i] = o.vs;
  endtask

  task automatic push_source(input int i);
    for (int j = 3; j >= 1; j--) hist[i][j] = hist[i][j-1];
    hist[i][0] = src_val(i, obs[i].x, obs[i].y, mode);
    data_r[i]  = hist[i][P_LAT[i]];
  endtask

  task automatic clear_trackers();
    for (int i = 0; i < NI; i++) begin
      p_hs[i] = 1'b1;  p_vs[i] = 1'b1;
      hf_seen[i] = 1'b0; hl_seen[i] = 1'b0; vl_seen[i] = 1'b0;
      fr_seen[i] = 1'b0; first_done[i] = 1'b0;
      last_hf[i] = 0; hs_low[i] = 0; vs_low[i] = 0;
      de_cnt[i] = 0; white_cnt[i] = 0; last_fr[i] = 0;
    end
  endtask

  // One clock: count the edge, then sample and respond on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) k++;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      compare_inst(i);
      if (rst_n) measure(i);
      push_source(i);
    end
  endtask

  // Assert reset between edges, confirm the pins drop at once, hold, release on a falling edge.
  task automatic do_reset(input int cycles, input int new_mode);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    k     = 0;
    mode  = new_mode;
    #1;
    for (int i = 0; i < NI; i++) compare_inst(i);
    repeat (cycles) step();
    rst_n = 1'b1;
    clear_trackers();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      salt[i]   = 8'($urandom_range(1, 255));
      data_r[i] = '0;
      for (int j = 0; j < 4; j++) hist[i][j] = '0;
    end
    salt[3] = 8'h5A;
    clear_trackers();

    repeat (3) step();
    rst_n = 1'b1;

    // Pattern source; stop mid-line on an active row of the full raster.
    repeat (36 * 800 + 400 + int'($urandom_range(0, 40)) - 20) step();
    for (int i = 0; i < NI; i++) begin
      cur_i = i;
      check("first_frame_seen", 32'(first_done[i]), 1);
    end

    do_reset(3 + int'($urandom_range(0, 2)), 1);
    repeat (600 + int'($urandom_range(0, 200))) step();

    do_reset(3 + int'($urandom_range(0, 2)), 2);
    repeat (28200) step();
    for (int i = 0; i < NI; i++) begin
      cur_i = i;
      check("first_frame_seen", 32'(first_done[i]), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
